// File: rtl/addr4u_pkg.sv
`default_nettype none
// ============================================================================
// Module : addr4u_pkg
// Brief  : Shared widths, state encoding and golden-sum helper for the
//          4-bit adder check stage.
// Rev    : 1.0 - initial release
// ============================================================================
package addr4u_pkg;

    localparam int OP_W  = 4;
    localparam int SUM_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } addr4u_chk_state_e;

    function automatic logic [SUM_W-1:0] golden_sum(
        input logic [OP_W-1:0] a,
        input logic [OP_W-1:0] b
    );
        golden_sum = {1'b0, a} + {1'b0, b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/addr4u_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module : addr4u_sat_cnt
// Brief  : Saturating up-counter with synchronous clear (clear beats inc).
// Rev    : 1.0 - initial release
// ============================================================================
module addr4u_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/addr4u_check_stage.sv
`default_nettype none
// ============================================================================
// Module : addr4u_check_stage
// Brief  : Launches operand pairs into an external 4-bit adder, waits a fixed
//          settle time, then checks the returned sum against A+B.
// Rev    : 1.0 - initial release
// ============================================================================
module addr4u_check_stage
    import addr4u_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_a,
    input  logic [OP_W-1:0]  in_b,
    output logic [OP_W-1:0]  add_a,
    output logic [OP_W-1:0]  add_b,
    input  logic [SUM_W-1:0] add_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic             out_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] txn_count,
    input  logic             clr_cnt
);

    localparam logic [3:0] c_SETTLE_INIT = 4'(SETTLE_CYC);

    addr4u_chk_state_e r_state;
    logic [3:0]        r_settle;
    logic [OP_W-1:0]   r_add_a;
    logic [OP_W-1:0]   r_add_b;
    logic [SUM_W-1:0]  r_golden;
    logic [SUM_W-1:0]  r_sum;
    logic              r_err;
    logic              r_sticky;

    logic w_accept;
    logic w_capture;
    logic w_mismatch;

    assign in_ready   = (r_state == IDLE) && !rst;
    assign w_accept   = in_valid && in_ready;
    assign w_capture  = (r_state == SETTLE) && (r_settle == 4'd0);
    assign w_mismatch = (add_sum != r_golden);

    // Operands stay on the adder inputs until the next accept so the DUT
    // output is never disturbed while it settles or while a result is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_settle <= 4'd0;
            r_add_a  <= '0;
            r_add_b  <= '0;
            r_golden <= '0;
            r_sum    <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_add_a  <= in_a;
                        r_add_b  <= in_b;
                        r_golden <= golden_sum(in_a, in_b);
                        r_settle <= c_SETTLE_INIT;
                        r_state  <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (r_settle != 4'd0) begin
                        r_settle <= r_settle - 4'd1;
                    end else begin
                        r_sum   <= add_sum;
                        r_err   <= w_mismatch;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            r_sticky <= 1'b0;
        end else if (w_capture && w_mismatch) begin
            r_sticky <= 1'b1;
        end
    end

    addr4u_sat_cnt #(.W(CNT_W)) u_txn_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (w_capture),
        .cnt (txn_count)
    );

    addr4u_sat_cnt #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (w_capture && w_mismatch),
        .cnt (err_count)
    );

    assign add_a      = r_add_a;
    assign add_b      = r_add_b;
    assign out_valid  = (r_state == HOLD);
    assign out_sum    = r_sum;
    assign out_err    = r_err;
    assign err_sticky = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_addr4u_check_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_addr4u_check_stage
// Brief  : Directed self-checking bench; u_dut0 uses default parameters,
//          u_dut1 uses SETTLE_CYC=0 and CNT_W=2.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_addr4u_check_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // ---- u_dut0 : SETTLE_CYC=2, CNT_W=8
    logic       rst0 = 1'b1, in_valid0 = 1'b0, out_ready0 = 1'b0, clr0 = 1'b0, bad0 = 1'b0;
    logic [3:0] in_a0 = 4'h0, in_b0 = 4'h0;
    logic       in_ready0, out_valid0, out_err0, sticky0;
    logic [3:0] add_a0, add_b0;
    logic [4:0] add_sum0, out_sum0;
    logic [7:0] err_cnt0, txn_cnt0;

    assign add_sum0 = bad0 ? 5'h00 : ({1'b0, add_a0} + {1'b0, add_b0});

    addr4u_check_stage #(.SETTLE_CYC(2), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst(rst0), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_a(in_a0), .in_b(in_b0), .add_a(add_a0), .add_b(add_b0),
        .add_sum(add_sum0), .out_valid(out_valid0), .out_ready(out_ready0),
        .out_sum(out_sum0), .out_err(out_err0), .err_sticky(sticky0),
        .err_count(err_cnt0), .txn_count(txn_cnt0), .clr_cnt(clr0)
    );

    // ---- u_dut1 : SETTLE_CYC=0, CNT_W=2
    logic       rst1 = 1'b1, in_valid1 = 1'b0, out_ready1 = 1'b0, clr1 = 1'b0, bad1 = 1'b0;
    logic [3:0] in_a1 = 4'h0, in_b1 = 4'h0;
    logic       in_ready1, out_valid1, out_err1, sticky1;
    logic [3:0] add_a1, add_b1;
    logic [4:0] add_sum1, out_sum1;
    logic [1:0] err_cnt1, txn_cnt1;

    assign add_sum1 = bad1 ? 5'h00 : ({1'b0, add_a1} + {1'b0, add_b1});

    addr4u_check_stage #(.SETTLE_CYC(0), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .add_a(add_a1), .add_b(add_b1),
        .add_sum(add_sum1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_sum(out_sum1), .out_err(out_err1), .err_sticky(sticky1),
        .err_count(err_cnt1), .txn_count(txn_cnt1), .clr_cnt(clr1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one pair on u_dut0, return edges from accept edge to out_valid.
    task automatic txn0(input logic [3:0] a, input logic [3:0] b, output int lat);
        in_a0 = a; in_b0 = b; in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        lat = 0;
        while (!out_valid0 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic txn1(input logic [3:0] a, input logic [3:0] b, output int lat);
        in_a1 = a; in_b1 = b; in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic drain0();
        out_ready0 = 1'b1;
        tick();
        out_ready0 = 1'b0;
        chk("drain0_ov", 32'(out_valid0), 32'd0);
        chk("drain0_rdy", 32'(in_ready0), 32'd1);
    endtask

    task automatic drain1();
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        chk("drain1_ov", 32'(out_valid1), 32'd0);
    endtask

    initial begin
        int lat;

        // ---------------- reset state
        tick(); tick();
        chk("rst_in_ready", 32'(in_ready0), 32'd0);
        chk("rst_out_valid", 32'(out_valid0), 32'd0);
        chk("rst_add_a", 32'(add_a0), 32'd0);
        chk("rst_txn", 32'(txn_cnt0), 32'd0);
        chk("rst_err", 32'(err_cnt0), 32'd0);
        chk("rst_sticky", 32'(sticky0), 32'd0);
        rst0 = 1'b0; rst1 = 1'b0;
        #1;
        chk("post_rst_ready", 32'(in_ready0), 32'd1);

        // ---------------- 5 + A, correct adder, latency 3
        txn0(4'h5, 4'hA, lat);
        chk("t1_latency", 32'(lat), 32'd3);
        chk("t1_add_a", 32'(add_a0), 32'h5);
        chk("t1_add_b", 32'(add_b0), 32'hA);
        chk("t1_sum", 32'(out_sum0), 32'h0F);
        chk("t1_err", 32'(out_err0), 32'd0);
        chk("t1_txn", 32'(txn_cnt0), 32'd1);
        chk("t1_errcnt", 32'(err_cnt0), 32'd0);
        drain0();

        // ---------------- F + F, carry out
        txn0(4'hF, 4'hF, lat);
        chk("t2_latency", 32'(lat), 32'd3);
        chk("t2_sum", 32'(out_sum0), 32'h1E);
        chk("t2_carry", 32'(out_sum0[4]), 32'd1);
        chk("t2_err", 32'(out_err0), 32'd0);
        chk("t2_txn", 32'(txn_cnt0), 32'd2);
        drain0();

        // ---------------- 3 + 4 with broken adder
        bad0 = 1'b1;
        txn0(4'h3, 4'h4, lat);
        bad0 = 1'b0;
        chk("t3_sum", 32'(out_sum0), 32'h00);
        chk("t3_err", 32'(out_err0), 32'd1);
        chk("t3_sticky", 32'(sticky0), 32'd1);
        chk("t3_errcnt", 32'(err_cnt0), 32'd1);
        chk("t3_txn", 32'(txn_cnt0), 32'd3);

        // ---------------- back-pressure in HOLD, in_valid pulses ignored
        for (int i = 0; i < 10; i++) begin
            in_valid0 = i[0];
            in_a0 = 4'h9; in_b0 = 4'h6;
            tick();
            chk("hold_ov", 32'(out_valid0), 32'd1);
            chk("hold_sum", 32'(out_sum0), 32'h00);
            chk("hold_err", 32'(out_err0), 32'd1);
            chk("hold_rdy", 32'(in_ready0), 32'd0);
            chk("hold_add_a", 32'(add_a0), 32'h3);
        end
        in_valid0 = 1'b0;
        drain0();
        chk("post_hold_add_a", 32'(add_a0), 32'h3);
        chk("post_hold_txn", 32'(txn_cnt0), 32'd3);
        tick();
        chk("single_hs_ov", 32'(out_valid0), 32'd0);

        // ---------------- reset during SETTLE
        in_a0 = 4'h1; in_b0 = 4'h2; in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        tick();
        rst0 = 1'b1;
        tick();
        chk("abort_ov", 32'(out_valid0), 32'd0);
        chk("abort_add_a", 32'(add_a0), 32'd0);
        chk("abort_txn", 32'(txn_cnt0), 32'd0);
        chk("abort_errcnt", 32'(err_cnt0), 32'd0);
        chk("abort_sticky", 32'(sticky0), 32'd0);
        chk("abort_rdy", 32'(in_ready0), 32'd0);
        rst0 = 1'b0;
        tick();
        chk("abort_rdy_after", 32'(in_ready0), 32'd1);
        chk("abort_ov_after", 32'(out_valid0), 32'd0);

        // ---------------- u_dut1: SETTLE_CYC=0 latency
        txn1(4'h7, 4'h8, lat);
        chk("s0_latency", 32'(lat), 32'd1);
        chk("s0_sum", 32'(out_sum1), 32'h0F);
        chk("s0_txn", 32'(txn_cnt1), 32'd1);
        drain1();

        // ---------------- u_dut1: saturation with CNT_W=2
        bad1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            txn1(4'(i), 4'h1, lat);
            chk("sat_err", 32'(out_err1), 32'd1);
            drain1();
        end
        chk("sat_errcnt", 32'(err_cnt1), 32'd3);
        chk("sat_txn", 32'(txn_cnt1), 32'd3);
        chk("sat_sticky", 32'(sticky1), 32'd1);

        // ---------------- clr_cnt on the capture edge wins over increment
        in_a1 = 4'h2; in_b1 = 4'h2; in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        clr1 = 1'b1;
        tick();
        clr1 = 1'b0;
        chk("clr_ov", 32'(out_valid1), 32'd1);
        chk("clr_err", 32'(out_err1), 32'd1);
        chk("clr_errcnt", 32'(err_cnt1), 32'd0);
        chk("clr_txn", 32'(txn_cnt1), 32'd0);
        chk("clr_sticky", 32'(sticky1), 32'd0);
        bad1 = 1'b0;
        drain1();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/addr4u_check_stage.md
Name: addr4u_check_stage

Overview:
- Sequential wrapper that sits directly around our combinational unsigned 4-bit adders (pareto area/delay variants).
- Upstream side: accepts operand pairs over a valid/ready stream and drives them, registered and stable, onto the adder inputs.
- Waits a programmable number of cycles for the adder to settle, then samples its 5-bit sum.
- Checks the sum against a locally computed golden A+B, forwards the result downstream with an error flag, and keeps saturating transaction and mismatch counters for resilience measurement.

Parameters:
- SETTLE_CYC, 2, number of settle cycles between operand launch and sum capture; legal range 0..15.
- CNT_W, 8, width of err_count and txn_count.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operand pair
- in_a  in  4  operand A, unsigned
- in_b  in  4  operand B, unsigned
- add_a  out  4  registered operand A driven to the adder under test
- add_b  out  4  registered operand B driven to the adder under test
- add_sum  in  5  sum returned by the adder under test; bit 4 is carry-out
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_sum  out  5  captured adder sum
- out_err  out  1  captured sum differs from golden sum
- err_sticky  out  1  set on any mismatch since reset or clr_cnt
- err_count  out  CNT_W  number of mismatches, saturating
- txn_count  out  CNT_W  number of compared transactions, saturating
- clr_cnt  in  1  synchronous clear of both counters and err_sticky

Behaviour:
- Reset (rst=1 at an edge):
  - state goes to IDLE.
  - add_a, add_b, out_sum, out_err, out_valid, err_sticky, err_count and txn_count all become 0.
  - in_ready is 0 while rst is high.
  - Reset mid-operation aborts the transaction; no result is emitted.
- States: IDLE, SETTLE, HOLD.
- in_ready = (state==IDLE) and not rst. out_valid = (state==HOLD).
- IDLE:
  - On in_valid & in_ready: latch in_a/in_b into add_a/add_b, latch golden = {0,in_a}+{0,in_b} (5 bits), load settle counter with SETTLE_CYC, go to SETTLE.
  - add_a/add_b hold their last values and are never changed outside an accept.
- SETTLE:
  - If counter != 0: decrement.
  - If counter == 0: capture add_sum into out_sum, set out_err = (add_sum != golden), go to HOLD.
  - On that capture edge:
    - txn_count increments, saturating at all-ones.
    - If out_err, err_count increments (saturating) and err_sticky is set.
- Latency: out_valid rises SETTLE_CYC+1 edges after the accept edge (SETTLE_CYC=0 gives 1 edge).
- HOLD:
  - out_sum and out_err are stable until out_valid & out_ready.
  - On that handshake edge go to IDLE; out_valid drops.
  - There is no bypass, so the next accept is at the earliest one cycle later.
  - Peak throughput is one transaction per SETTLE_CYC+3 cycles.
- add_sum is sampled only on the capture edge; its value at all other times is ignored.
- clr_cnt:
  - Zeroes err_count, txn_count and err_sticky at the edge.
  - If it coincides with a capture edge, the clear wins and the counters read 0 afterwards; out_err still reflects the compare.
- Saturation: a counter at 2^CNT_W-1 stays there; it never wraps.
- in_valid while not ready is ignored and no data is latched; the upstream must hold its data.

Decomposition:
- Package addr4u_pkg:
  - OP_W=4, SUM_W=5.
  - State enum addr4u_chk_state_e {IDLE, SETTLE, HOLD}.
  - golden-sum function returning a SUM_W-bit value.
- One sub-module: addr4u_sat_cnt (parameter W; inputs clk, rst, clr, inc; output cnt; clr has priority over inc), instantiated twice.

Test Plan:
- Reset then accept a=4'h5, b=4'hA with add_sum tied to the correct sum:
  - out_valid rises 3 edges after accept, out_sum=5'h0F, out_err=0, txn_count=1, err_count=0.
- a=4'hF, b=4'hF, correct adder model:
  - out_sum=5'h1E; carry bit present; no error.
- Model forced to return 5'h00 for a=4'h3, b=4'h4:
  - out_err=1, err_sticky=1, err_count=1.
- out_ready held low for 10 cycles in HOLD:
  - out_sum/out_err stable.
  - in_ready=0 and in_valid pulses ignored.
  - Release gives one handshake, then IDLE.
- CNT_W=2, four forced-error transactions:
  - err_count=3 saturated; txn_count=3.
  - clr_cnt pulsed on the 5th capture edge: both counters 0 after that edge.
- rst asserted during SETTLE, and SETTLE_CYC=0:
  - rst during SETTLE gives no out_valid, everything zero, in_ready=1 the cycle after rst deasserts.
  - With SETTLE_CYC=0, out_valid rises 1 edge after accept.
